// File: rtl/xlr_batch_sequencer.sv
// Batch controller: walks a list of engine jobs programmed through the host register file,
// launching one job at a time and reporting busy/done/progress/error status back to the host.
module xlr_batch_sequencer #(
  parameter int LOG2_LINES_PER_MEM = 8,
  parameter int CNT_W              = 8,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0][31:0]             host_regs,
  input  logic [31:0]                   host_regs_valid_pulse,
  output logic [31:0][31:0]             host_regs_data_out,
  output logic [31:0]                   host_regs_valid_out,
  output logic                          eng_start,
  output logic [LOG2_LINES_PER_MEM-1:0] eng_src_addr,
  output logic [LOG2_LINES_PER_MEM-1:0] eng_dst_addr,
  input  logic                          eng_done,
  output logic [5:0]                    o_dbg_state
);

  localparam int LW    = LOG2_LINES_PER_MEM;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_ISSUE = 6'b000010,
    S_WAIT  = 6'b000100,
    S_ADV   = 6'b001000,
    S_FIN   = 6'b010000,
    S_ERR   = 6'b100000
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [LW-1:0]      r_src;
  logic [LW-1:0]      r_dst;
  logic [LW-1:0]      r_stride;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_jobs;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_busy;
  logic               r_done;
  logic [2:0]         r_error;

  logic               w_start;
  logic               w_abort;
  logic               w_start_ok;
  logic               w_abort_ok;
  logic               w_tmo_hit;
  logic [CNT_W-1:0]   w_cnt_in;
  logic               w_unused_bits;

  assign w_start    = host_regs_valid_pulse[0] && (host_regs[0] == 32'd1);
  assign w_abort    = host_regs_valid_pulse[7] && (host_regs[7] == 32'd1);
  assign w_cnt_in   = host_regs[6][CNT_W-1:0];
  assign w_start_ok = w_start && (r_state == S_IDLE);
  assign w_abort_ok = w_abort &&
                      ((r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_ADV));
  // Last WAIT cycle before the limit; an eng_done in this same cycle still wins.
  assign w_tmo_hit  = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  assign w_unused_bits = ^{host_regs, host_regs_valid_pulse};

  // Engine handshake: eng_start is a one-cycle launch pulse (ISSUE state); addresses stay
  // stable until the engine answers with a one-cycle eng_done pulse, which is only
  // honoured in WAIT and ignored in every other state.
  assign eng_start    = (r_state == S_ISSUE);
  assign eng_src_addr = r_src;
  assign eng_dst_addr = r_dst;
  assign o_dbg_state  = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next = (w_cnt_in == '0) ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_next = w_abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (w_abort) begin
          w_next = S_IDLE;
        end else if (eng_done) begin
          w_next = S_ADV;
        end else if (w_tmo_hit) begin
          w_next = S_ERR;
        end
      end
      S_ADV: begin
        if (w_abort) begin
          w_next = S_IDLE;
        end else begin
          w_next = (r_jobs == r_count) ? S_FIN : S_ISSUE;
        end
      end
      S_FIN:   w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src    <= '0;
      r_dst    <= '0;
      r_stride <= '0;
      r_count  <= '0;
      r_jobs   <= '0;
      r_tmo    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= '0;
    end else begin
      if (w_start_ok) begin
        r_src    <= host_regs[3][LW-1:0];
        r_dst    <= host_regs[4][LW-1:0];
        r_stride <= host_regs[5][LW-1:0];
        r_count  <= w_cnt_in;
        r_jobs   <= '0;
        r_tmo    <= '0;
        r_busy   <= 1'b1;
        r_done   <= 1'b0;
        r_error  <= '0;
      end

      if (w_start && (r_state != S_IDLE)) begin
        r_error[1] <= 1'b1;
      end

      if ((r_state == S_WAIT) && !w_abort) begin
        r_tmo <= r_tmo + TMO_W'(1);
        if (eng_done) begin
          r_jobs <= r_jobs + CNT_W'(1);
        end
      end

      if ((r_state == S_ADV) && !w_abort) begin
        r_src <= r_src + r_stride;
        r_dst <= r_dst + r_stride;
        r_tmo <= '0;
      end

      // Terminal transitions override the start branch (zero-length batch goes straight to FIN).
      if (w_next == S_FIN) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
      if (w_next == S_ERR) begin
        r_busy     <= 1'b0;
        r_error[0] <= 1'b1;
      end
      if (w_abort_ok) begin
        r_busy     <= 1'b0;
        r_error[2] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_regs_data_out <= '0;
    end else begin
      host_regs_data_out    <= '0;
      host_regs_data_out[1] <= {31'd0, r_busy};
      host_regs_data_out[2] <= {31'd0, r_done};
      host_regs_data_out[8] <= 32'(r_jobs);
      host_regs_data_out[9] <= {29'd0, r_error};
    end
  end

  assign host_regs_valid_out = {22'd0, 1'b1, 1'b1, 5'd0, host_regs_data_out[2][0], 1'b1, 1'b0};

endmodule

// File: tb/tb_xlr_batch_sequencer.sv
// Directed bench for xlr_batch_sequencer: table of batch configurations plus hand-written
// sequences for timeout, abort, start-while-busy, simultaneous start/abort and mid-batch reset.
module tb_xlr_batch_sequencer;

  localparam logic [5:0] ST_IDLE = 6'b000001;
  localparam logic [5:0] ST_WAIT = 6'b000100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0][31:0] host_regs;
  logic [31:0]       host_regs_valid_pulse;
  logic [31:0][31:0] host_regs_data_out;
  logic [31:0]       host_regs_valid_out;
  logic              eng_start;
  logic [7:0]        eng_src_addr;
  logic [7:0]        eng_dst_addr;
  logic              eng_done = 1'b0;
  logic [5:0]        dbg_state;

  int n_checks = 0;
  int n_err = 0;

  xlr_batch_sequencer #(
    .LOG2_LINES_PER_MEM(8),
    .CNT_W(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .host_regs(host_regs),
    .host_regs_valid_pulse(host_regs_valid_pulse),
    .host_regs_data_out(host_regs_data_out),
    .host_regs_valid_out(host_regs_valid_out),
    .eng_start(eng_start),
    .eng_src_addr(eng_src_addr),
    .eng_dst_addr(eng_dst_addr),
    .eng_done(eng_done),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endfunction

  // engine model and launch scoreboard: expected {src,dst} per eng_start
  logic [15:0] exp_q[$];
  logic [15:0] exp_pair;
  int          eng_delay = 4;
  int          eng_cnt = 0;
  logic        force_done = 1'b0;
  int          n_starts = 0;

  always @(posedge clk) begin
    #1;
    eng_done = force_done;
    if (!rst_n) begin
      eng_cnt = 0;
    end else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) eng_done = 1'b1;
      end
      if (eng_start) begin
        n_starts++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_eng_start: got src=0x%0h dst=0x%0h required no launch",
                   eng_src_addr, eng_dst_addr);
        end else begin
          exp_pair = exp_q.pop_front();
          check("eng_addr", {16'd0, eng_src_addr, eng_dst_addr}, {16'd0, exp_pair});
        end
        if (eng_delay > 0) eng_cnt = eng_delay;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic host_write(input int idx, input logic [31:0] val);
    host_regs[idx] = val;
    host_regs_valid_pulse[idx] = 1'b1;
    tick();
    host_regs_valid_pulse[idx] = 1'b0;
  endtask

  task automatic configure(input logic [7:0] src, input logic [7:0] dst,
                           input logic [7:0] stride, input logic [7:0] count, input int delay);
    logic [7:0] s;
    logic [7:0] d;
    host_regs[3] = {24'd0, src};
    host_regs[4] = {24'd0, dst};
    host_regs[5] = {24'd0, stride};
    host_regs[6] = {24'd0, count};
    eng_delay = delay;
    s = src;
    d = dst;
    for (int i = 0; i < int'(count); i++) begin
      exp_q.push_back({s, d});
      s = s + stride;
      d = d + stride;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    tick();
    while ((dbg_state != ST_IDLE) && (n < 2000)) begin
      tick();
      n++;
    end
    if (dbg_state != ST_IDLE) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_idle_wait: got state 0x%0h required 0x%0h", name, dbg_state, ST_IDLE);
    end
    tick();
    tick();
  endtask

  task automatic check_status(input string name, input logic [31:0] jobs, input logic [31:0] done,
                              input logic [31:0] err, input logic [31:0] busy);
    check({name, "_jobs"}, host_regs_data_out[8], jobs);
    check({name, "_done"}, host_regs_data_out[2], done);
    check({name, "_err"},  host_regs_data_out[9], err);
    check({name, "_busy"}, host_regs_data_out[1], busy);
    check({name, "_valid"}, host_regs_valid_out, 32'h0000_0302 | (done << 2));
  endtask

  typedef struct {
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [7:0]  stride;
    logic [7:0]  count;
    int          delay;
    logic [31:0] jobs;
    logic [31:0] done;
    logic [31:0] err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int base;
    int n;
    int n_d;

    vecs[0] = '{8'h00, 8'h40, 8'h01, 8'd3, 4,  32'd3, 32'd1, 32'd0};
    vecs[1] = '{8'h00, 8'h00, 8'h01, 8'd0, 4,  32'd0, 32'd1, 32'd0};
    vecs[2] = '{8'hFE, 8'hFF, 8'h01, 8'd3, 4,  32'd3, 32'd1, 32'd0};
    vecs[3] = '{8'h10, 8'h80, 8'h30, 8'd4, 1,  32'd4, 32'd1, 32'd0};
    vecs[4] = '{8'hF0, 8'h00, 8'h08, 8'd3, 16, 32'd3, 32'd1, 32'd0};

    host_regs = '0;
    host_regs_valid_pulse = '0;
    repeat (3) @(posedge clk);
    #2;

    // reset state
    check("rst_data_out", {31'd0, |host_regs_data_out}, 32'd0);
    check("rst_valid_out", host_regs_valid_out, 32'h0000_0302);
    check("rst_eng_start", {31'd0, eng_start}, 32'd0);
    check("rst_addrs", {16'd0, eng_src_addr, eng_dst_addr}, 32'd0);
    check("rst_state", {26'd0, dbg_state}, {26'd0, ST_IDLE});
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      base = n_starts;
      configure(vecs[v].src, vecs[v].dst, vecs[v].stride, vecs[v].count, vecs[v].delay);
      host_write(0, 32'd1);
      wait_idle($sformatf("vec%0d", v));
      check_status($sformatf("vec%0d", v), vecs[v].jobs, vecs[v].done, vecs[v].err, 32'd0);
      check($sformatf("vec%0d_starts", v), n_starts - base, {24'd0, vecs[v].count});
      check($sformatf("vec%0d_q_empty", v), exp_q.size(), 0);
    end

    // engine timeout after 16 WAIT cycles; a late eng_done is ignored
    base = n_starts;
    configure(8'h05, 8'h06, 8'h03, 8'd2, 0);
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    host_write(0, 32'd1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (dbg_state == ST_WAIT) n++;
      else if (n > 0) break;
      tick();
    end
    check("tmo_wait_cycles", n, 16);
    wait_idle("tmo");
    check_status("tmo", 32'd0, 32'd0, 32'd1, 32'd0);
    check("tmo_starts", n_starts - base, 1);
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    tick();
    tick();
    check("tmo_late_done_state", {26'd0, dbg_state}, {26'd0, ST_IDLE});
    check_status("tmo_late", 32'd0, 32'd0, 32'd1, 32'd0);

    // abort on the cycle of the 2nd eng_done
    base = n_starts;
    configure(8'h20, 8'h60, 8'h02, 8'd5, 4);
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    host_write(0, 32'd1);
    n_d = 0;
    for (int i = 0; i < 500; i++) begin
      if (eng_done) begin
        n_d++;
        if (n_d == 2) break;
      end
      tick();
    end
    check("abort_done_seen", n_d, 2);
    host_write(7, 32'd1);
    wait_idle("abort");
    repeat (20) tick();
    check_status("abort", 32'd1, 32'd0, 32'd4, 32'd0);
    check("abort_starts", n_starts - base, 2);
    check("abort_q_empty", exp_q.size(), 0);

    // START during the 2nd job is ignored but flagged
    base = n_starts;
    configure(8'h00, 8'h40, 8'h01, 8'd3, 4);
    host_write(0, 32'd1);
    for (int i = 0; i < 500; i++) begin
      if (n_starts - base >= 2) break;
      tick();
    end
    check("swb_second_start", n_starts - base, 2);
    host_write(0, 32'd1);
    wait_idle("swb");
    check_status("swb", 32'd3, 32'd1, 32'd2, 32'd0);
    check("swb_starts", n_starts - base, 3);

    // simultaneous START and ABORT in IDLE: START wins, zero-length batch
    configure(8'h00, 8'h00, 8'h01, 8'd0, 4);
    host_regs[0] = 32'd1;
    host_regs[7] = 32'd1;
    host_regs_valid_pulse[0] = 1'b1;
    host_regs_valid_pulse[7] = 1'b1;
    tick();
    host_regs_valid_pulse = '0;
    wait_idle("sa");
    check_status("sa", 32'd0, 32'd1, 32'd0, 32'd0);

    // reset pulsed mid-WAIT
    base = n_starts;
    configure(8'h33, 8'h44, 8'h01, 8'd3, 0);
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    host_write(0, 32'd1);
    for (int i = 0; i < 50; i++) begin
      if (dbg_state == ST_WAIT) break;
      tick();
    end
    repeat (3) tick();
    check("rstmid_busy_before", host_regs_data_out[1], 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_data_out", {31'd0, |host_regs_data_out}, 32'd0);
    check("rstmid_state", {26'd0, dbg_state}, {26'd0, ST_IDLE});
    check("rstmid_eng_start", {31'd0, eng_start}, 32'd0);
    check("rstmid_addrs", {16'd0, eng_src_addr, eng_dst_addr}, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("rstmid_starts", n_starts - base, 1);
    check("rstmid_q_empty", exp_q.size(), 0);
    check("rstmid_valid_out", host_regs_valid_out, 32'h0000_0302);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
